// File: rtl/hyperbus_tf_scheduler.sv
// HyperBus transfer scheduler: round-robin arbitration of transfer requesters and
// splitting of linear bursts into CS#-time-bounded chunks, one chunk in flight at a time.

package hyperbus_tf_scheduler_pkg;
  localparam int HyperBurstWidth = 12;

  typedef struct packed {
    logic [31:0]                address;
    logic [HyperBurstWidth-1:0] burst;
    logic                       burst_type;  // 1: linear, 0: wrapped
    logic                       write;
    logic                       address_space;
  } hyper_tf_t;

  typedef struct packed {
    logic [15:0] t_burst_max;
  } hyper_cfg_t;
endpackage

module hyperbus_tf_scheduler
  import hyperbus_tf_scheduler_pkg::*;
#(
  parameter  int NumReq = 2,
  localparam int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  hyper_cfg_t        cfg_i,
  input  hyper_tf_t         req_tf_i [NumReq],
  input  logic [NumReq-1:0] req_valid_i,
  output logic [NumReq-1:0] req_ready_o,
  output logic [NumReq-1:0] req_done_o,
  output logic [IdxW-1:0]   gnt_idx_o,
  output hyper_tf_t         phy_tf_o,
  output logic              phy_valid_o,
  input  logic              phy_ready_i,
  output logic              phy_last_o,
  input  logic              phy_done_i
);

  localparam int BW = HyperBurstWidth;
  localparam logic [BW-1:0] BurstMax = '1;
  localparam logic [BW-1:0] BurstOne = {{(BW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ZERO} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   rr_q, rr_d;
  logic [IdxW-1:0]   gnt_q, gnt_d;
  hyper_tf_t         tf_q, tf_d;
  logic [BW-1:0]     rem_q, rem_d;
  logic [31:0]       addr_q, addr_d;
  logic [BW-1:0]     lim_q, lim_d;
  logic              phy_valid_q, phy_valid_d;
  hyper_tf_t         phy_tf_q, phy_tf_d;
  logic              phy_last_q, phy_last_d;
  logic [NumReq-1:0] done_q, done_d;

  logic [NumReq-1:0] req_ready_s;
  logic              found_s;
  logic [IdxW-1:0]   win_s;
  logic              load_s;
  logic [BW-1:0]     chunk_s;

  function automatic logic [BW-1:0] chunk_limit(input hyper_cfg_t cfg);
    if (cfg.t_burst_max == 16'd0) begin
      return BurstOne;
    end else if (32'(cfg.t_burst_max) > 32'(BurstMax)) begin
      return BurstMax;
    end else begin
      return BW'(cfg.t_burst_max);
    end
  endfunction

  // Wrapped bursts must stay in one CS# window, so only linear ones are split.
  function automatic logic [BW-1:0] chunk_of(input logic linear, input logic [BW-1:0] rem,
                                             input logic [BW-1:0] lim);
    if (linear && (rem > lim)) begin
      return lim;
    end else begin
      return rem;
    end
  endfunction

  // Arbitration, chunking and next-state logic
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    tf_d        = tf_q;
    rem_d       = rem_q;
    addr_d      = addr_q;
    lim_d       = lim_q;
    phy_valid_d = phy_valid_q;
    phy_tf_d    = phy_tf_q;
    phy_last_d  = phy_last_q;
    done_d      = '0;
    req_ready_s = '0;
    load_s      = 1'b0;
    chunk_s     = '0;
    found_s     = 1'b0;
    win_s       = '0;

    for (int i = 0; i < NumReq; i++) begin
      int idx;
      idx = int'(rr_q) + i;
      if (idx >= NumReq) begin
        idx = idx - NumReq;
      end
      if (!found_s && req_valid_i[idx]) begin
        found_s = 1'b1;
        win_s   = IdxW'(idx);
      end
    end

    case (state_q)
      IDLE: begin
        // A done pulse still on the outputs blocks acceptance for that cycle.
        if (found_s && (done_q == '0)) begin
          req_ready_s[win_s] = 1'b1;
          tf_d   = req_tf_i[win_s];
          rem_d  = req_tf_i[win_s].burst;
          addr_d = req_tf_i[win_s].address;
          lim_d  = chunk_limit(cfg_i);
          gnt_d  = win_s;
          if (int'(win_s) == NumReq - 1) begin
            rr_d = '0;
          end else begin
            rr_d = win_s + IdxW'(1'b1);
          end
          if (req_tf_i[win_s].burst == '0) begin
            done_d[win_s] = 1'b1;
            state_d       = ZERO;
          end else begin
            load_s  = 1'b1;
            state_d = ISSUE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ZERO: begin
        state_d = IDLE;
      end
      ISSUE: begin
        if (phy_ready_i) begin
          rem_d       = rem_q - phy_tf_q.burst;
          addr_d      = addr_q + 32'({phy_tf_q.burst, 1'b0});
          phy_valid_d = 1'b0;
          state_d     = WAIT;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT: begin
        if (phy_done_i) begin
          if (rem_q == '0) begin
            done_d[gnt_q] = 1'b1;
            state_d       = IDLE;
          end else begin
            load_s  = 1'b1;
            state_d = ISSUE;
          end
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d     = IDLE;
        phy_valid_d = 1'b0;
      end
    endcase

    if (load_s) begin
      chunk_s           = chunk_of(tf_d.burst_type, rem_d, lim_d);
      phy_tf_d          = tf_d;
      phy_tf_d.address  = addr_d;
      phy_tf_d.burst    = chunk_s;
      phy_last_d        = (chunk_s == rem_d);
      phy_valid_d       = 1'b1;
    end else begin
      chunk_s = '0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      gnt_q       <= '0;
      tf_q        <= '0;
      rem_q       <= '0;
      addr_q      <= 32'd0;
      lim_q       <= '0;
      phy_valid_q <= 1'b0;
      phy_tf_q    <= '0;
      phy_last_q  <= 1'b0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      tf_q        <= tf_d;
      rem_q       <= rem_d;
      addr_q      <= addr_d;
      lim_q       <= lim_d;
      phy_valid_q <= phy_valid_d;
      phy_tf_q    <= phy_tf_d;
      phy_last_q  <= phy_last_d;
      done_q      <= done_d;
    end
  end

  assign req_ready_o = req_ready_s;
  assign req_done_o  = done_q;
  assign gnt_idx_o   = gnt_q;
  assign phy_tf_o    = phy_tf_q;
  assign phy_valid_o = phy_valid_q;
  assign phy_last_o  = phy_last_q;

endmodule

// File: tb/tb_hyperbus_tf_scheduler.sv
// Scoreboard bench for hyperbus_tf_scheduler: a request-level model expands each accepted
// transfer into its expected chunk list; a separate monitor checks PHY commands and done pulses.

module tb_hyperbus_tf_scheduler;
  import hyperbus_tf_scheduler_pkg::*;

  localparam int NR = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  hyper_cfg_t    cfg_i;
  hyper_tf_t     req_tf_i [NR];
  logic [NR-1:0] req_valid_i, req_ready_o, req_done_o;
  logic [0:0]    gnt_idx_o;
  hyper_tf_t     phy_tf_o;
  logic          phy_valid_o, phy_ready_i, phy_last_o, phy_done_i;

  hyperbus_tf_scheduler #(.NumReq(NR)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_i(cfg_i), .req_tf_i(req_tf_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_done_o(req_done_o),
    .gnt_idx_o(gnt_idx_o), .phy_tf_o(phy_tf_o), .phy_valid_o(phy_valid_o),
    .phy_ready_i(phy_ready_i), .phy_last_o(phy_last_o), .phy_done_i(phy_done_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { hyper_tf_t tf; logic last; } exp_chunk_t;
  typedef struct { int idx; int cyc; bit zero; } exp_done_t;

  exp_chunk_t exp_q[$];
  exp_done_t  exp_done_q[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int model_rr, in_flight, wait_cnt, stall_force, ready_pct, gen_left, refill_left;
  int first_cyc;
  bit outstanding, hold_done, rand_en, await_first, dir_cfg_pend;
  logic [NR-1:0] clear_mask, dir_pend;
  hyper_tf_t  dir_tf [NR];
  hyper_cfg_t dir_cfg;
  bit prev_stall;
  logic [47:0] prev_cmd;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Request-level model: expand one accepted transfer into its chunk sequence.
  task automatic predict(input int idx, input hyper_tf_t tf, input hyper_cfg_t cfg, input int acc_cyc);
    int lim, rem, c;
    logic [31:0] a;
    exp_chunk_t e;
    exp_done_t d;
    if (cfg.t_burst_max == 16'd0) lim = 1;
    else if (int'(cfg.t_burst_max) > (1 << HyperBurstWidth) - 1) lim = (1 << HyperBurstWidth) - 1;
    else lim = int'(cfg.t_burst_max);
    rem = int'(tf.burst);
    a   = tf.address;
    while (rem > 0) begin
      c = (tf.burst_type && rem > lim) ? lim : rem;
      e.tf = tf;
      e.tf.address = a;
      e.tf.burst = HyperBurstWidth'(c);
      e.last = (c == rem);
      exp_q.push_back(e);
      rem = rem - c;
      a = a + 32'(2 * c);
    end
    d.idx = idx; d.cyc = acc_cyc; d.zero = (tf.burst == '0);
    exp_done_q.push_back(d);
  endtask

  function automatic hyper_tf_t rand_tf();
    hyper_tf_t t;
    t.address       = $urandom;
    t.burst         = ($urandom_range(0, 7) == 0) ? '0 : HyperBurstWidth'($urandom_range(1, 40));
    t.burst_type    = 1'($urandom_range(0, 1));
    t.write         = 1'($urandom_range(0, 1));
    t.address_space = 1'($urandom_range(0, 1));
    return t;
  endfunction

  function automatic hyper_tf_t mk_tf(input logic [31:0] a, input int b, input logic lin);
    hyper_tf_t t;
    t = '0;
    t.address = a; t.burst = HyperBurstWidth'(b); t.burst_type = lin; t.write = 1'b1;
    return t;
  endfunction

  // One bench cycle: drive at negedge, then record what the next rising edge will accept.
  task automatic step();
    int w, idx;
    @(negedge clk_i);
    for (int i = 0; i < NR; i++) begin
      if (clear_mask[i]) begin
        req_valid_i[i] = 1'b0;
        if (refill_left > 0) begin
          req_tf_i[i] = mk_tf(32'h0000_0200 + 32'(i * 16), 1, 1'b1);
          req_valid_i[i] = 1'b1;
          refill_left--;
        end
      end
    end
    clear_mask = '0;
    if (outstanding && !hold_done) begin
      if (wait_cnt == 0) begin phy_done_i = 1'b1; outstanding = 1'b0; end
      else begin wait_cnt--; phy_done_i = 1'b0; end
    end else begin
      phy_done_i = (!outstanding && rand_en && $urandom_range(0, 7) == 0);
    end
    if (stall_force > 0) begin phy_ready_i = 1'b0; stall_force--; end
    else phy_ready_i = ($urandom_range(0, 99) < ready_pct);
    if (dir_cfg_pend) begin cfg_i = dir_cfg; dir_cfg_pend = 1'b0; end
    if (rand_en && in_flight == 0 && req_valid_i == '0 && $urandom_range(0, 3) == 0)
      cfg_i.t_burst_max = ($urandom_range(0, 5) == 0) ? 16'd5000 : 16'($urandom_range(0, 8));
    for (int i = 0; i < NR; i++) begin
      if (dir_pend[i]) begin
        req_tf_i[i] = dir_tf[i]; req_valid_i[i] = 1'b1; dir_pend[i] = 1'b0;
      end else if (rand_en && !req_valid_i[i] && gen_left > 0 && $urandom_range(0, 3) == 0) begin
        req_tf_i[i] = rand_tf(); req_valid_i[i] = 1'b1; gen_left--;
      end
    end
    #1;
    if (req_ready_o != '0) begin
      w = -1;
      for (int k = 0; k < NR; k++)
        if (w < 0 && req_valid_i[(model_rr + k) % NR]) w = (model_rr + k) % NR;
      check("grant", 64'(req_ready_o), (w < 0) ? 64'd0 : (64'd1 << w));
      check("accept_while_busy", 64'(in_flight), 64'd0);
      idx = 0;
      for (int k = NR - 1; k >= 0; k--) if (req_ready_o[k]) idx = k;
      predict(idx, req_tf_i[idx], cfg_i, cyc);
      if (req_tf_i[idx].burst != '0) begin await_first = 1'b1; first_cyc = cyc + 1; end
      in_flight++;
      model_rr = (idx + 1) % NR;
      clear_mask[idx] = 1'b1;
    end
    if (phy_valid_o && phy_ready_i) begin
      outstanding = 1'b1;
      wait_cnt = $urandom_range(0, 3);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    do begin step(); n++; end
    while (n < budget && (req_valid_i != '0 || in_flight != 0 || clear_mask != '0 || dir_pend != '0));
    check({name, "_timeout"}, 64'(in_flight != 0 || req_valid_i != '0), 64'd0);
  endtask

  // Monitor: compare PHY commands and done pulses against the scoreboard.
  always @(negedge clk_i) begin
    exp_chunk_t e;
    exp_done_t d;
    #2;
    if (rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (await_first && cyc >= first_cyc) begin
        check("first_chunk_latency", 64'(phy_valid_o), 64'd1);
        await_first = 1'b0;
      end
      if (prev_stall)
        check("hold_during_stall", {15'd0, phy_valid_o, phy_tf_o, phy_last_o}, {15'd0, 1'b1, prev_cmd});
      if (phy_valid_o && phy_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_chunk", 64'(phy_tf_o), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("chunk_cmd", 64'(phy_tf_o), 64'(e.tf));
          check("chunk_last", 64'(phy_last_o), 64'(e.last));
          if (exp_done_q.size() > 0) check("gnt_idx", 64'(gnt_idx_o), 64'(exp_done_q[0].idx));
        end
      end
      prev_stall = phy_valid_o && !phy_ready_i;
      prev_cmd   = {phy_tf_o, phy_last_o};
      if (req_done_o != '0) begin
        if (exp_done_q.size() == 0) begin
          check("unexpected_done", 64'(req_done_o), 64'd0);
        end else begin
          d = exp_done_q.pop_front();
          check("done_idx", 64'(req_done_o), 64'd1 << d.idx);
          check("done_chunks_left", 64'(exp_q.size()), 64'd0);
          if (d.zero) check("zero_done_latency", 64'(cyc), 64'(d.cyc + 1));
          in_flight--;
        end
      end
    end
  end

  task automatic issue(input int idx, input hyper_tf_t tf, input int tbm);
    dir_cfg.t_burst_max = 16'(tbm);
    dir_cfg_pend = 1'b1;
    dir_tf[idx] = tf;
    dir_pend[idx] = 1'b1;
  endtask

  initial begin
    int n;
    rst_i = 1'b1; cfg_i = '0; req_valid_i = '0; phy_ready_i = 1'b0; phy_done_i = 1'b0;
    for (int i = 0; i < NR; i++) begin req_tf_i[i] = '0; dir_tf[i] = '0; end
    model_rr = 0; in_flight = 0; wait_cnt = 0; stall_force = 0; ready_pct = 100; gen_left = 0;
    refill_left = 0; outstanding = 0; hold_done = 0; rand_en = 0; await_first = 0;
    dir_cfg_pend = 0; clear_mask = '0; dir_pend = '0; dir_cfg = '0; first_cyc = 0;
    prev_stall = 0; prev_cmd = '0;
    #1;
    check("reset_outputs", {req_ready_o, req_done_o, gnt_idx_o, phy_valid_o, phy_last_o, phy_tf_o}, 64'd0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    // Linear split 10 words in chunks of 4
    issue(0, mk_tf(32'h0000_0100, 10, 1'b1), 4);
    drain("linear_split", 200);
    // Continuous requests on both ports: grants must alternate
    refill_left = 4;
    issue(0, mk_tf(32'h0000_0200, 1, 1'b1), 4);
    issue(1, mk_tf(32'h0000_0210, 1, 1'b1), 4);
    drain("alternate", 300);
    // Wrapped bursts are never split
    issue(1, mk_tf(32'h0000_0400, 32, 1'b0), 4);
    drain("wrapped", 200);
    // t_burst_max of zero gives single-word chunks; zero-length request
    issue(0, mk_tf(32'h0000_0800, 3, 1'b1), 0);
    drain("tbm_zero", 200);
    issue(1, mk_tf(32'h0000_0900, 0, 1'b1), 4);
    drain("zero_burst", 50);
    // PHY stalls for 5 cycles in ISSUE
    stall_force = 6;
    issue(0, mk_tf(32'h0000_0A00, 2, 1'b1), 8);
    drain("stall", 100);
    // Address wrap at 4 GiB
    issue(1, mk_tf(32'hFFFF_FFFC, 4, 1'b1), 2);
    drain("addr_wrap", 200);

    // Reset while a chunk is outstanding
    hold_done = 1'b1;
    issue(0, mk_tf(32'h0000_1000, 6, 1'b1), 2);
    n = 0;
    while (!outstanding && n < 50) begin step(); n++; end
    check("reach_wait", 64'(outstanding), 64'd1);
    step(); step();
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("reset_mid_transfer", {req_ready_o, req_done_o, gnt_idx_o, phy_valid_o, phy_last_o, phy_tf_o}, 64'd0);
    exp_q.delete(); exp_done_q.delete();
    in_flight = 0; model_rr = 0; outstanding = 0; hold_done = 0; await_first = 0;
    req_valid_i = '0; clear_mask = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (5) step();
    issue(0, mk_tf(32'h0000_2000, 1, 1'b1), 4);
    issue(1, mk_tf(32'h0000_2100, 1, 1'b1), 4);
    drain("post_reset_rr", 200);

    // Randomized traffic
    rand_en = 1'b1; gen_left = 80; ready_pct = 70;
    for (int k = 0; k < 1500 && gen_left > 0; k++) step();
    rand_en = 1'b0;
    drain("random", 3000);
    repeat (5) step();
    check("leftover_expected", 64'(exp_q.size() + exp_done_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
